// File: rtl/pdp8_mem_pkg.sv
// Shared types for the 32Kx12 SRAM cycle sequencer: op codes, FSM states,
// request bundle and word/address widths.
package pdp8_mem_pkg;

  localparam int DW = 12;  // data word
  localparam int FW = 3;   // memory field
  localparam int AW = 15;  // field + word address
  localparam int CW = 8;   // cycle counter

  typedef enum logic [1:0] {
    MEM_RD  = 2'b00,
    MEM_WR  = 2'b01,
    MEM_INC = 2'b10,
    MEM_RSV = 2'b11
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } mem_state_e;

  typedef struct packed {
    mem_op_e       op;
    logic [FW-1:0] field;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  // Counter load value for a phase lasting n cycles (terminal count is 0).
  function automatic logic [CW-1:0] cyc_load(input int n);
    return CW'(n - 1);
  endfunction

endpackage

// File: rtl/ram_port_arb.sv
// 2:1 fixed-priority request mux (break port wins) and the grant latch that
// holds the accepted request for the whole memory cycle.
module ram_port_arb
  import pdp8_mem_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     cpu_req,
  input  mem_req_t cpu_pkt,
  input  logic     brk_req,
  input  mem_req_t brk_pkt,
  input  logic     take,
  output logic     any_req,
  output mem_req_t sel_pkt,
  output mem_req_t cur_pkt,
  output logic     cur_brk
);

  assign any_req = cpu_req | brk_req;
  assign sel_pkt = brk_req ? brk_pkt : cpu_pkt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_pkt <= '0;
      cur_brk <= 1'b0;
    end else if (take) begin
      cur_pkt <= sel_pkt;
      cur_brk <= brk_req;
    end
  end

endmodule

// File: rtl/ram_cycle_ctl.sv
// Memory-cycle sequencer for the 32Kx12 async SRAM: arbitrates CPU/break
// requests and drives registered CE_N/WE_N/A/DI with programmable timing.
module ram_cycle_ctl
  import pdp8_mem_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int RD_CYC    = 1,
  parameter int WR_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [1:0]    cpu_op,
  input  logic [FW-1:0] cpu_field,
  input  logic [DW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_zero,
  input  logic          brk_req,
  input  logic [1:0]    brk_op,
  input  logic [FW-1:0] brk_field,
  input  logic [DW-1:0] brk_addr,
  input  logic [DW-1:0] brk_wdata,
  output logic          brk_ack,
  output logic [DW-1:0] brk_rdata,
  output logic          brk_zero,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic          ram_ce_n,
  output logic          ram_we_n,
  output logic          busy
);

  mem_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  mem_req_t      cpu_pkt, brk_pkt, sel_pkt, cur_pkt;
  logic          cpu_go, brk_go, any_req, cur_brk, take;
  logic          ce_n_nx, we_n_nx, a_ld, di_ld, cap, fin;
  logic [DW-1:0] di_nx, inc_val, rd_q;
  logic          zero_q, is_inc;

  assign cpu_pkt = '{op: mem_op_e'(cpu_op), field: cpu_field, addr: cpu_addr, wdata: cpu_wdata};
  assign brk_pkt = '{op: mem_op_e'(brk_op), field: brk_field, addr: brk_addr, wdata: brk_wdata};

  // A requester still holds req during its ack cycle; mask it so it is not re-served.
  assign cpu_go = cpu_req & ~cpu_ack;
  assign brk_go = brk_req & ~brk_ack;

  ram_port_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .cpu_req (cpu_go),
    .cpu_pkt (cpu_pkt),
    .brk_req (brk_go),
    .brk_pkt (brk_pkt),
    .take    (take),
    .any_req (any_req),
    .sel_pkt (sel_pkt),
    .cur_pkt (cur_pkt),
    .cur_brk (cur_brk)
  );

  assign is_inc  = (cur_pkt.op == MEM_INC);
  assign inc_val = ram_do + DW'(1);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ce_n_nx  = ram_ce_n;
    we_n_nx  = ram_we_n;
    di_nx    = ram_di;
    take     = 1'b0;
    a_ld     = 1'b0;
    di_ld    = 1'b0;
    cap      = 1'b0;
    fin      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          take     = 1'b1;
          a_ld     = 1'b1;
          ce_n_nx  = 1'b0;
          cnt_nx   = cyc_load(SETUP_CYC);
          state_nx = ST_SETUP;
          // Present write data early so DI is settled before WE_N falls.
          if (sel_pkt.op == MEM_WR) begin
            di_ld = 1'b1;
            di_nx = sel_pkt.wdata;
          end
        end
      end
      ST_SETUP: begin
        if (cnt != '0) cnt_nx = cnt - CW'(1);
        else if (cur_pkt.op == MEM_WR) begin
          di_ld    = 1'b1;
          di_nx    = cur_pkt.wdata;
          we_n_nx  = 1'b0;
          cnt_nx   = cyc_load(WR_CYC);
          state_nx = ST_WRITE;
        end else begin
          cnt_nx   = cyc_load(RD_CYC);
          state_nx = ST_READ;
        end
      end
      ST_READ: begin
        if (cnt != '0) cnt_nx = cnt - CW'(1);
        else begin
          cap = 1'b1;
          if (is_inc) begin
            di_ld    = 1'b1;
            di_nx    = inc_val;
            we_n_nx  = 1'b0;
            cnt_nx   = cyc_load(WR_CYC);
            state_nx = ST_WRITE;
          end else begin
            ce_n_nx  = 1'b1;
            state_nx = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        if (cnt != '0) cnt_nx = cnt - CW'(1);
        else begin
          we_n_nx  = 1'b1;
          cnt_nx   = cyc_load(HOLD_CYC);
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt != '0) cnt_nx = cnt - CW'(1);
        else begin
          ce_n_nx  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        fin      = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        ce_n_nx  = 1'b1;
        we_n_nx  = 1'b1;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_a     <= '0;
      ram_di    <= '0;
      ram_ce_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      cnt       <= '0;
      rd_q      <= '0;
      zero_q    <= 1'b0;
      cpu_ack   <= 1'b0;
      brk_ack   <= 1'b0;
      cpu_rdata <= '0;
      brk_rdata <= '0;
      cpu_zero  <= 1'b0;
      brk_zero  <= 1'b0;
    end else begin
      ram_ce_n <= ce_n_nx;
      ram_we_n <= we_n_nx;
      cnt      <= cnt_nx;
      cpu_ack  <= fin & ~cur_brk;
      brk_ack  <= fin & cur_brk;
      if (a_ld)  ram_a  <= {sel_pkt.field, sel_pkt.addr};
      if (di_ld) ram_di <= di_nx;
      if (cap) begin
        rd_q   <= is_inc ? inc_val : ram_do;
        zero_q <= is_inc && (inc_val == '0);
      end
      if (fin && cur_brk) begin
        if (cur_pkt.op != MEM_WR) brk_rdata <= rd_q;
        brk_zero <= is_inc & zero_q;
      end
      if (fin && !cur_brk) begin
        if (cur_pkt.op != MEM_WR) cpu_rdata <= rd_q;
        cpu_zero <= is_inc & zero_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_cycle_ctl.sv
// Bench for ram_cycle_ctl: behavioural SRAM, reference memory and an
// expected-result queue popped on each ack; second instance sweeps timing.
module tb_ram_cycle_ctl;
  import pdp8_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_req = 0, brk_req = 0;
  logic [1:0]  cpu_op = 0, brk_op = 0;
  logic [2:0]  cpu_field = 0, brk_field = 0;
  logic [11:0] cpu_addr = 0, brk_addr = 0, cpu_wdata = 0, brk_wdata = 0;
  logic        cpu_ack, brk_ack, cpu_zero, brk_zero, ram_ce_n, ram_we_n, busy;
  logic [11:0] cpu_rdata, brk_rdata, ram_di, ram_do;
  logic [14:0] ram_a;

  logic        s_req = 0;
  logic [1:0]  s_op = 0;
  logic [11:0] s_addr = 0, s_wdata = 0;
  logic        s_ack, s_zero, s_brk_ack, s_brk_zero, s_ce_n, s_we_n, s_busy;
  logic [11:0] s_rdata, s_brk_rdata, s_di, s_do;
  logic [14:0] s_a;

  ram_cycle_ctl u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_field(cpu_field), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_zero(cpu_zero),
    .brk_req(brk_req), .brk_op(brk_op), .brk_field(brk_field), .brk_addr(brk_addr),
    .brk_wdata(brk_wdata), .brk_ack(brk_ack), .brk_rdata(brk_rdata), .brk_zero(brk_zero),
    .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do), .ram_ce_n(ram_ce_n),
    .ram_we_n(ram_we_n), .busy(busy)
  );

  ram_cycle_ctl #(.SETUP_CYC(2), .RD_CYC(3), .WR_CYC(4), .HOLD_CYC(2)) u_swp (
    .clk(clk), .reset(reset),
    .cpu_req(s_req), .cpu_op(s_op), .cpu_field(3'd0), .cpu_addr(s_addr),
    .cpu_wdata(s_wdata), .cpu_ack(s_ack), .cpu_rdata(s_rdata), .cpu_zero(s_zero),
    .brk_req(1'b0), .brk_op(2'b00), .brk_field(3'd0), .brk_addr(12'd0),
    .brk_wdata(12'd0), .brk_ack(s_brk_ack), .brk_rdata(s_brk_rdata), .brk_zero(s_brk_zero),
    .ram_a(s_a), .ram_di(s_di), .ram_do(s_do), .ram_ce_n(s_ce_n),
    .ram_we_n(s_we_n), .busy(s_busy)
  );

  // Behavioural async SRAMs; the bench preloads through pl_* ports.
  logic [11:0] mem   [0:32767];
  logic [11:0] s_mem [0:32767];
  logic [11:0] ref_m [0:32767];
  logic        pl_en = 0;
  logic [14:0] pl_a = 0;
  logic [11:0] pl_d = 0;

  assign ram_do = mem[ram_a];
  assign s_do   = s_mem[s_a];

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!ram_ce_n && !ram_we_n) mem[ram_a] <= ram_di;
  end
  always @(posedge clk) if (!s_ce_n && !s_we_n) s_mem[s_a] <= s_di;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
  endtask

  typedef struct {
    logic        is_brk;
    logic [11:0] rdata;
    logic        zero;
  } exp_t;
  exp_t        sb[$];
  logic [11:0] last_cpu = 0, last_brk = 0;

  task automatic preload(input logic [14:0] a, input logic [11:0] d);
    @(negedge clk);
    pl_en = 1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 0;
    ref_m[a] = d;
  endtask

  task automatic sb_push(input logic brk, input logic [1:0] op, input logic [14:0] ad,
                         input logic [11:0] wd);
    exp_t e;
    e.is_brk = brk;
    e.zero   = 1'b0;
    if (op == MEM_WR) begin
      ref_m[ad] = wd;
      e.rdata = brk ? last_brk : last_cpu;
    end else if (op == MEM_INC) begin
      ref_m[ad] = ref_m[ad] + 12'd1;
      e.rdata = ref_m[ad];
      e.zero  = (ref_m[ad] == 12'd0);
    end else begin
      e.rdata = ref_m[ad];
    end
    if (brk) last_brk = e.rdata; else last_cpu = e.rdata;
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("ack_port", int'(brk_ack), int'(e.is_brk));
    chk("rdata", brk_ack ? brk_rdata : cpu_rdata, e.rdata);
    chk("zero", brk_ack ? brk_zero : cpu_zero, e.zero);
  endtask

  // Issue one request and wait for its ack; lat counts edges after the accept edge.
  task automatic do_op(input logic brk, input logic [1:0] op, input logic [14:0] ad,
                       input logic [11:0] wd, output int lat, output int we_low,
                       output int viol, output logic [14:0] wa, output logic [11:0] wdi);
    logic [14:0] pa;
    logic [11:0] pd;
    logic        pwe, got, done;
    @(negedge clk);
    sb_push(brk, op, ad, wd);
    if (brk) begin
      brk_op = op; brk_field = ad[14:12]; brk_addr = ad[11:0]; brk_wdata = wd; brk_req = 1;
    end else begin
      cpu_op = op; cpu_field = ad[14:12]; cpu_addr = ad[11:0]; cpu_wdata = wd; cpu_req = 1;
    end
    lat = 0; we_low = 0; viol = 0; wa = 0; wdi = 0; done = 0;
    pa = ram_a; pd = ram_di; pwe = ram_we_n;
    while (!done) begin
      @(posedge clk);
      @(negedge clk);
      if (!ram_we_n) begin
        we_low++; wa = ram_a; wdi = ram_di;
      end
      if ((!ram_we_n || !pwe) && (ram_a != pa || ram_di != pd)) viol++;
      pa = ram_a; pd = ram_di; pwe = ram_we_n;
      got = brk ? brk_ack : cpu_ack;
      if (got) begin
        sb_pop();
        done = 1;
      end else begin
        lat++;
        if (lat > 40) begin
          chk("ack_timeout", 0, 1);
          void'(sb.pop_back());
          done = 1;
        end
      end
    end
    brk_req = 0; cpu_req = 0;
  endtask

  task automatic s_run(input string tag, input logic [1:0] op, input logic [11:0] a,
                       input logic [11:0] wd, input int exp_lat, input logic [11:0] exp_rd);
    int lat;
    @(negedge clk);
    s_op = op; s_addr = a; s_wdata = wd; s_req = 1;
    lat = 0;
    while (!s_ack && lat <= 40) begin
      @(posedge clk);
      @(negedge clk);
      if (!s_ack) lat++;
    end
    s_req = 0;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, s_rdata, exp_rd);
  endtask

  initial begin
    int lat, wl, vi, tb_k, tc_k, ack_seen;
    logic [14:0] wa;
    logic [11:0] wd;

    preload(15'o05123, 12'o4321);
    preload(15'o00010, 12'o0005);
    preload(15'o01000, 12'o7777);
    @(negedge clk);
    chk("rst_ce_n", ram_ce_n, 1);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_a", ram_a, 0);
    chk("rst_di", ram_di, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {cpu_ack, brk_ack}, 0);
    chk("rst_rdata", {cpu_rdata, brk_rdata}, 0);
    reset = 0;

    do_op(0, MEM_RD, 15'o05123, 0, lat, wl, vi, wa, wd);
    chk("rd_lat", lat, 3);
    chk("rd_we_low", wl, 0);

    do_op(0, MEM_WR, 15'o77777, 12'o1234, lat, wl, vi, wa, wd);
    chk("wr_lat", lat, 5);
    chk("wr_we_low", wl, 2);
    chk("wr_stable", vi, 0);
    chk("wr_a", wa, 15'o77777);
    chk("wr_di", wd, 12'o1234);
    do_op(0, MEM_RD, 15'o77777, 0, lat, wl, vi, wa, wd);

    do_op(0, MEM_INC, 15'o01000, 0, lat, wl, vi, wa, wd);
    chk("inc_lat", lat, 6);
    chk("inc_we_low", wl, 2);
    do_op(0, MEM_RD, 15'o01000, 0, lat, wl, vi, wa, wd);
    do_op(0, MEM_INC, 15'o00010, 0, lat, wl, vi, wa, wd);
    do_op(0, MEM_RSV, 15'o05123, 0, lat, wl, vi, wa, wd);
    chk("rsv_lat", lat, 3);
    chk("rsv_we_low", wl, 0);

    // Same-cycle tie: break must be served first.
    @(negedge clk);
    sb_push(1, MEM_RD, 15'o05123, 0);
    sb_push(0, MEM_RD, 15'o00010, 0);
    brk_op = MEM_RD; brk_field = 3'o0; brk_addr = 12'o5123; brk_req = 1;
    cpu_op = MEM_RD; cpu_field = 3'o0; cpu_addr = 12'o0010; cpu_req = 1;
    tb_k = 0; tc_k = 0;
    for (int k = 0; k <= 40 && tc_k == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (brk_ack) begin
        tb_k = k; brk_req = 0; sb_pop();
      end
      if (cpu_ack) begin
        tc_k = k; cpu_req = 0; sb_pop();
      end
    end
    cpu_req = 0; brk_req = 0;
    chk("tie_brk_lat", tb_k, 3);
    chk("tie_cpu_after", int'(tc_k >= tb_k + 2), 1);

    // Reset in the middle of a write pulse aborts cleanly.
    @(negedge clk);
    cpu_op = MEM_WR; cpu_field = 3'o2; cpu_addr = 12'o0300; cpu_wdata = 12'o5555; cpu_req = 1;
    for (int k = 0; k < 10 && ram_we_n; k++) @(negedge clk);
    chk("abort_in_write", ram_we_n, 0);
    reset = 1; cpu_req = 0;
    @(negedge clk);
    chk("abort_we_n", ram_we_n, 1);
    chk("abort_ce_n", ram_ce_n, 1);
    chk("abort_busy", busy, 0);
    reset = 0;
    ack_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (cpu_ack || brk_ack) ack_seen++;
      @(negedge clk);
    end
    chk("abort_no_ack", ack_seen, 0);
    last_cpu = 0;  // reset clears rdata
    do_op(0, MEM_RD, 15'o05123, 0, lat, wl, vi, wa, wd);
    chk("post_rst_lat", lat, 3);

    s_run("swp_wr", MEM_WR, 12'o0100, 12'o1111, 9, 12'o0000);
    s_run("swp_rd", MEM_RD, 12'o0100, 0, 6, 12'o1111);
    s_run("swp_inc", MEM_INC, 12'o0100, 0, 12, 12'o1112);
    chk("swp_zero", s_zero, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
